// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/state enums and baud divisor helper for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO read port between the sync FIFO and its serial drain
interface uart_tx_drain_if #(parameter int DATA_WIDTH = 8);
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  modport master (input empty, input rd_data, output rd_en);
  modport slave (output empty, output rd_data, input rd_en);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts CLKS_PER_BIT cycles per bit and pulses bit_done on the last one
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_done = run && cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (restart || bit_done) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops words from a sync FIFO and serialises them as back-to-back UART frames
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ_HZ = 100_000_000,
  parameter int      BAUD_RATE   = 115_200,
  parameter int      DATA_WIDTH  = 8,
  parameter int      DATA_BITS   = 8,
  parameter parity_e PARITY      = PAR_NONE,
  parameter int      STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  uart_tx_drain_if.master  fifo,
  output logic             tx,
  output logic             busy
);
  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int IW  = $clog2(DATA_BITS + 1);
  generate
    if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || DATA_BITS > DATA_WIDTH ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $fatal(1, "uart_tx_drain: illegal parameter combination");
    end
  endgenerate
  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] sh, sh_n, word;
  logic [IW-1:0]        idx, idx_n;
  logic                 par, par_n, tx_n, pop, bit_done, last_stop;
  assign word      = fifo.rd_data[DATA_BITS-1:0];
  assign last_stop = state == ST_STOP && bit_done && idx == IW'(STOP_BITS - 1);
  // pops happen only from idle or on the very last stop cycle, giving gapless frames
  assign pop       = !rst && en && !fifo.empty && (state == ST_IDLE || last_stop);
  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (pop),
    .run      (state != ST_IDLE),
    .bit_done (bit_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      sh    <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      idx   <= idx_n;
      par   <= par_n;
      tx    <= tx_n;
      busy  <= state_n != ST_IDLE;
    end
  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    par_n   = par;
    if (pop) begin
      state_n = ST_START;
      sh_n    = word;
      idx_n   = '0;
      par_n   = PARITY == PAR_ODD ? ~^word : ^word;
    end else if (bit_done) begin
      case (state)
        ST_START:  state_n = ST_DATA;
        ST_DATA: begin
          sh_n    = sh >> 1;
          idx_n   = idx == IW'(DATA_BITS - 1) ? '0 : idx + 1'b1;
          state_n = idx != IW'(DATA_BITS - 1) ? ST_DATA : PARITY == PAR_NONE ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: state_n = ST_STOP;
        ST_STOP: begin
          idx_n   = last_stop ? '0 : idx + 1'b1;
          state_n = last_stop ? ST_IDLE : ST_STOP;
        end
        default:   state_n = ST_IDLE;
      endcase
    end
  end
  // tx is registered from the next-state view so line and state change on the same edge
  always_comb begin
    fifo.rd_en = pop;
    tx_n = state_n == ST_START  ? 1'b0 :
           state_n == ST_DATA   ? sh_n[0] :
           state_n == ST_PARITY ? par_n : 1'b1;
  end
endmodule
